// File: rtl/ahb2_sram_slv_if.sv
// AHB2 slave-port signal bundle between the bus fabric and ahb2_sram_slv.
// Latency: none, wires only.
// Backpressure: the fabric loops hreadyo back onto hreadyi.
interface ahb2_sram_slv_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [3:0]            hprot;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hreadyi;
  logic [DATA_WIDTH-1:0] hrdata;
  logic [1:0]            hresp;
  logic                  hreadyo;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hreadyi,
    input  hrdata, hresp, hreadyo
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hreadyi,
    output hrdata, hresp, hreadyo
  );
endinterface

// File: rtl/ahb2_sram_slv.sv
// AHB2 SRAM responder: word array with byte lanes, wait states and 2-cycle ERROR.
// Latency: data phase is WAIT_CYCLES+1 cycles for OKAY, 2 cycles for ERROR.
// Backpressure: hreadyo low during wait states and ERR1; next address accepted on hreadyi.
module ahb2_sram_slv #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            rst,
  ahb2_sram_slv_if.slave  bus
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int AQ_W  = IDX_W + 2;
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH) << 2;
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              dphase_q, dphase_d;   // an OKAY data phase is in flight
  logic [AQ_W-1:0]   addr_q, addr_d;
  logic              write_q, write_d;
  logic [2:0]        size_q, size_d;
  logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic             accept;
  logic             req_err;
  logic             take_new;
  logic             hreadyo_w;
  logic             herr_w;
  logic             we_w;
  logic             rd_phase;
  logic [3:0]       be_w;
  logic [IDX_W-1:0] word_idx;
  logic             unused_ok;

  assign accept = bus.hsel & bus.hreadyi & bus.htrans[1];

  // Address-phase legality: range, size, and natural alignment of the transfer.
  always_comb begin
    req_err = 1'b0;
    if ({1'b0, bus.haddr} >= MEM_BYTES)                        req_err = 1'b1;
    if (bus.hsize > 3'd2)                                      req_err = 1'b1;
    if ((bus.hsize == 3'd1) && bus.haddr[0])                   req_err = 1'b1;
    if ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00))      req_err = 1'b1;
  end

  // Next-state, counter, address-phase latch and bus response outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dphase_d  = dphase_q;
    addr_d    = addr_q;
    write_d   = write_q;
    size_d    = size_q;
    take_new  = 1'b0;
    hreadyo_w = 1'b1;
    herr_w    = 1'b0;
    case (state_q)
      S_IDLE: begin
        dphase_d = 1'b0;
        take_new = 1'b1;
      end
      S_WAIT: begin
        hreadyo_w = 1'b0;
        cnt_d     = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = S_IDLE;
      end
      S_ERR1: begin
        hreadyo_w = 1'b0;
        herr_w    = 1'b1;
        state_d   = S_ERR2;
      end
      S_ERR2: begin
        herr_w   = 1'b1;
        state_d  = S_IDLE;
        take_new = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (take_new && accept) begin
      addr_d  = bus.haddr[AQ_W-1:0];
      write_d = bus.hwrite;
      size_d  = bus.hsize;
      if (req_err) begin
        state_d  = S_ERR1;
        dphase_d = 1'b0;
      end else if (WAIT_CYCLES > 0) begin
        state_d  = S_WAIT;
        cnt_d    = WAIT_INIT;
        dphase_d = 1'b1;
      end else begin
        state_d  = S_IDLE;
        dphase_d = 1'b1;
      end
    end
  end

  // FSM and address-phase registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      dphase_q <= 1'b0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= 3'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dphase_q <= dphase_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      size_q   <= size_d;
    end
  end

  // Little-endian byte-lane enables from latched size and low address bits.
  always_comb begin
    case (size_q)
      3'd0:    be_w = 4'b0001 << addr_q[1:0];
      3'd1:    be_w = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be_w = 4'b1111;
    endcase
  end

  assign word_idx = addr_q[AQ_W-1:2];
  // Write commits only on the completing (hreadyo high) cycle of an OKAY data phase.
  assign we_w     = (state_q == S_IDLE) & dphase_q & write_q;
  assign rd_phase = dphase_q & ~write_q;
  // Reads see the array directly so a write completing at the read's accept edge is visible.
  assign hrdata_d = rd_phase ? mem_q[word_idx] : hrdata_q;

  // Byte-lane write into the array; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_w) begin
      for (int b = 0; b < 4; b++) begin
        if (be_w[b]) mem_q[word_idx][8*b +: 8] <= bus.hwdata[8*b +: 8];
      end
    end
  end

  // Hold the last read word outside read data phases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hrdata_q <= '0;
    else     hrdata_q <= hrdata_d;
  end

  assign bus.hrdata  = hrdata_d;
  assign bus.hreadyo = hreadyo_w;
  assign bus.hresp   = herr_w ? 2'b01 : 2'b00;

  // Burst type, protection and the BUSY/IDLE distinction do not affect this responder.
  assign unused_ok = ^{bus.hburst, bus.hprot, bus.htrans[0]};

endmodule

// File: tb/tb_ahb2_sram_slv.sv
`timescale 1ns/1ps
module tb_ahb2_sram_slv;
  localparam int DEPTH = 1024;
  localparam int W1    = 3;
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NS = 2'd2, SEQ = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // dut0: zero wait states, dut1: W1 wait states
  logic        m_hsel   [2];
  logic [31:0] m_haddr  [2];
  logic [1:0]  m_htrans [2];
  logic        m_hwrite [2];
  logic [2:0]  m_hsize  [2];
  logic [2:0]  m_hburst [2];
  logic [3:0]  m_hprot  [2];
  logic [31:0] m_hwdata [2];
  logic        s_hreadyo[2];
  logic [1:0]  s_hresp  [2];
  logic [31:0] s_hrdata [2];

  ahb2_sram_slv_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  ahb2_sram_slv_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

  assign bus0.hsel = m_hsel[0];   assign bus1.hsel = m_hsel[1];
  assign bus0.haddr = m_haddr[0]; assign bus1.haddr = m_haddr[1];
  assign bus0.htrans = m_htrans[0]; assign bus1.htrans = m_htrans[1];
  assign bus0.hwrite = m_hwrite[0]; assign bus1.hwrite = m_hwrite[1];
  assign bus0.hsize = m_hsize[0]; assign bus1.hsize = m_hsize[1];
  assign bus0.hburst = m_hburst[0]; assign bus1.hburst = m_hburst[1];
  assign bus0.hprot = m_hprot[0]; assign bus1.hprot = m_hprot[1];
  assign bus0.hwdata = m_hwdata[0]; assign bus1.hwdata = m_hwdata[1];
  assign bus0.hreadyi = bus0.hreadyo; assign bus1.hreadyi = bus1.hreadyo;
  assign s_hreadyo[0] = bus0.hreadyo; assign s_hreadyo[1] = bus1.hreadyo;
  assign s_hresp[0] = bus0.hresp;   assign s_hresp[1] = bus1.hresp;
  assign s_hrdata[0] = bus0.hrdata; assign s_hrdata[1] = bus1.hrdata;

  ahb2_sram_slv #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(0))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  ahb2_sram_slv #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(W1))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  // reference model: byte-addressed view of each DUT's memory plus known-byte flags
  logic [31:0] ref_mem   [2][DEPTH];
  logic [3:0]  ref_known [2][DEPTH];
  logic [31:0] pend_wd   [2];

  typedef struct {
    logic        err;
    logic        rd;
    logic [31:0] data;
    logic [31:0] mask;
    int          lows;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h, required %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int d);
    if (d == 0) return q0.size();
    return q1.size();
  endfunction

  function automatic exp_t qfront(input int d);
    if (d == 0) return q0[0];
    return q1[0];
  endfunction

  task automatic qpop(input int d);
    if (d == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic qpush(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Present one address phase (and the previous transfer's write data), wait for
  // the bus to be ready, and record what the reference model predicts for it.
  task automatic xfer(input int d, input logic sel, input logic [1:0] tr, input logic wr,
                      input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    int guard;
    exp_t e;
    int idx;
    int lane0;
    int nb;
    @(negedge clk);
    m_hsel[d]   = sel;
    m_haddr[d]  = a;
    m_htrans[d] = tr;
    m_hwrite[d] = wr;
    m_hsize[d]  = sz;
    m_hburst[d] = 3'($urandom_range(0, 7));
    m_hprot[d]  = 4'($urandom_range(0, 15));
    m_hwdata[d] = pend_wd[d];
    guard = 0;
    while (!s_hreadyo[d] && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_within_bound", d, 32'(s_hreadyo[d]), 32'd1);
    pend_wd[d] = $urandom;
    if (sel && tr[1]) begin
      e.err  = (a >= 32'(DEPTH * 4)) || (sz > 3'd2) || ((a % (32'd1 << sz)) != 0);
      e.rd   = !wr;
      e.data = '0;
      e.mask = '0;
      e.lows = e.err ? 1 : ((d == 0) ? 0 : W1);
      if (!e.err) begin
        idx = int'(a / 4);
        if (wr) begin
          nb    = 1 << sz;
          lane0 = int'(a % 4);
          for (int k = 0; k < nb; k++) begin
            ref_mem[d][idx][8*(lane0+k) +: 8] = wd[8*(lane0+k) +: 8];
            ref_known[d][idx][lane0+k] = 1'b1;
          end
          pend_wd[d] = wd;
        end else begin
          e.data = ref_mem[d][idx];
          for (int k = 0; k < 4; k++)
            if (ref_known[d][idx][k]) e.mask[8*k +: 8] = 8'hFF;
        end
      end
      qpush(d, e);
    end
  endtask

  task automatic idle2(input int d);
    xfer(d, 1'b1, IDLE, 1'b0, 32'h0, 3'd0, 32'h0);
    xfer(d, 1'b1, IDLE, 1'b0, 32'h0, 3'd0, 32'h0);
  endtask

  task automatic directed(input int d);
    xfer(d, 1, NS, 1, 32'h10, 3'd2, 32'hDEADBEEF);
    xfer(d, 1, NS, 0, 32'h10, 3'd2, 32'h0);
    xfer(d, 1, NS, 1, 32'h20, 3'd2, 32'h00000000);
    xfer(d, 1, NS, 1, 32'h21, 3'd0, 32'h0000AA00);
    xfer(d, 1, NS, 1, 32'h22, 3'd1, 32'h12340000);
    xfer(d, 1, NS, 0, 32'h20, 3'd2, 32'h0);
    xfer(d, 1, NS, 1, 32'h00, 3'd2, 32'h11111111);
    xfer(d, 1, NS, 0, 32'h1000, 3'd2, 32'h0);
    xfer(d, 1, NS, 0, 32'h00, 3'd3, 32'h0);
    xfer(d, 1, NS, 0, 32'h02, 3'd2, 32'h0);
    xfer(d, 1, NS, 1, 32'h02, 3'd2, 32'hBAD0BAD0);
    xfer(d, 1, NS, 1, 32'h1000, 3'd2, 32'hBAD1BAD1);
    xfer(d, 1, NS, 1, 32'h01, 3'd1, 32'hBAD2BAD2);
    xfer(d, 1, NS, 1, 32'h00, 3'd4, 32'hBAD3BAD3);
    xfer(d, 1, NS, 0, 32'h00, 3'd2, 32'h0);
    xfer(d, 1, IDLE, 1, 32'h10, 3'd2, 32'h0);
    xfer(d, 1, BUSY, 1, 32'h10, 3'd2, 32'h0);
    xfer(d, 0, NS, 1, 32'h10, 3'd2, 32'h55555555);
    xfer(d, 0, SEQ, 1, 32'h10, 3'd2, 32'h66666666);
    xfer(d, 1, NS, 0, 32'h10, 3'd2, 32'h0);
    xfer(d, 1, NS, 1, 32'hFFC, 3'd2, 32'hCAFEF00D);
    xfer(d, 1, SEQ, 1, 32'hFFF, 3'd0, 32'h99000000);
    xfer(d, 1, SEQ, 0, 32'hFFC, 3'd2, 32'h0);
    xfer(d, 1, SEQ, 0, 32'h1002, 3'd1, 32'h0);
    xfer(d, 1, SEQ, 0, 32'h20, 3'd2, 32'h0);
    idle2(d);
  endtask

  task automatic random_run(input int d, input int n);
    int r;
    logic sel;
    logic [1:0] tr;
    logic [2:0] sz;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      r   = $urandom_range(0, 99);
      sel = (r < 90);
      tr  = (r < 80) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a   = ($urandom_range(0, 9) == 0) ? 32'(4096 + $urandom_range(0, 15))
                                        : 32'($urandom_range(0, 63));
      xfer(d, sel, tr, 1'($urandom_range(0, 1)), a, sz, $urandom);
    end
    idle2(d);
  endtask

  // Monitor: tracks accepted transfers on each bus and compares every data phase
  // against the front of that bus's expectation queue.
  bit act  [2];
  int lows [2];
  exp_t me;
  always begin
    @(negedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        act[d] = 1'b0;
        if (d == 0) q0.delete();
        else        q1.delete();
      end else begin
        if (act[d]) begin
          if (qsize(d) == 0) begin
            chk("expectation_available", d, 32'(qsize(d)), 32'd1);
            act[d] = 1'b0;
          end else begin
            me = qfront(d);
            if (!s_hreadyo[d]) begin
              lows[d]++;
              chk("hresp_during_wait", d, 32'(s_hresp[d]), me.err ? 32'd1 : 32'd0);
            end else begin
              chk("wait_state_count", d, 32'(lows[d]), 32'(me.lows));
              chk("hresp_on_completion", d, 32'(s_hresp[d]), me.err ? 32'd1 : 32'd0);
              if (me.rd && !me.err)
                chk("read_data", d, s_hrdata[d] & me.mask, me.data & me.mask);
              qpop(d);
              act[d] = 1'b0;
            end
          end
        end else begin
          chk("idle_hreadyo", d, 32'(s_hreadyo[d]), 32'd1);
          chk("idle_hresp", d, 32'(s_hresp[d]), 32'd0);
        end
        if (m_hsel[d] && m_htrans[d][1] && s_hreadyo[d]) begin
          act[d]  = 1'b1;
          lows[d] = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] save_word;
  logic [3:0]  save_known;

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_hsel[d] = 1'b0; m_haddr[d] = '0; m_htrans[d] = IDLE; m_hwrite[d] = 1'b0;
      m_hsize[d] = 3'd0; m_hburst[d] = 3'd0; m_hprot[d] = 4'd0; m_hwdata[d] = '0;
      pend_wd[d] = '0;
      for (int i = 0; i < DEPTH; i++) ref_known[d][i] = 4'b0000;
    end
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_hreadyo", d, 32'(s_hreadyo[d]), 32'd1);
      chk("reset_hresp", d, 32'(s_hresp[d]), 32'd0);
      chk("reset_hrdata", d, s_hrdata[d], 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    directed(0);
    directed(1);
    random_run(0, 150);
    random_run(1, 150);

    // reset asserted mid-write on the wait-state DUT
    xfer(1, 1, NS, 1, 32'h40, 3'd2, 32'h5A5A1234);
    xfer(1, 1, NS, 0, 32'h40, 3'd2, 32'h0);
    save_word  = ref_mem[1][16];
    save_known = ref_known[1][16];
    xfer(1, 1, NS, 1, 32'h40, 3'd2, 32'hFFFFFFFF);
    @(negedge clk);
    m_htrans[1] = IDLE;
    m_hwdata[1] = pend_wd[1];
    @(negedge clk);
    #1;
    chk("midwait_hreadyo", 1, 32'(s_hreadyo[1]), 32'd0);
    chk("hrdata_hold_during_write", 1, s_hrdata[1], 32'h5A5A1234);
    rst = 1'b1;
    #1;
    chk("abort_hreadyo", 1, 32'(s_hreadyo[1]), 32'd1);
    chk("abort_hresp", 1, 32'(s_hresp[1]), 32'd0);
    chk("abort_hrdata", 1, s_hrdata[1], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ref_mem[1][16]   = save_word;
    ref_known[1][16] = save_known;
    xfer(1, 1, NS, 0, 32'h40, 3'd2, 32'h0);
    xfer(1, 1, NS, 0, 32'h10, 3'd2, 32'h0);
    idle2(1);
    idle2(0);

    repeat (8) @(negedge clk);
    #3;
    chk("all_transfers_completed", 0, 32'(q0.size()), 32'd0);
    chk("all_transfers_completed", 1, 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb2_sram_slv.md
Name: ahb2_sram_slv

Overview:
AHB2 responder: the slave-side endpoint hanging off the AHB2 bus s0 port. It terminates address/data phases, stores data in an internal word-addressed array, and inserts a configurable number of wait states. It signals a two-cycle ERROR response for out-of-range or unsupported-size transfers. hreadyo is looped back by the bus to hreadyi, and the block's pipelining honours that loop.

Parameters:
ADDR_WIDTH, 32, haddr width
DATA_WIDTH, 32, hwdata/hrdata width (fixed 32 for this revision)
MEM_DEPTH, 1024, number of 32-bit words; valid byte range is 0 .. MEM_DEPTH*4-1
WAIT_CYCLES, 0, wait states (hreadyo low) per OKAY data phase; legal 0..7

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
hsel  in  1  slave select
haddr  in  ADDR_WIDTH  address-phase byte address
htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
hwrite  in  1  1=write
hsize  in  3  0=byte, 1=half, 2=word; larger values are illegal
hburst  in  3  burst type (ignored; each beat is treated independently)
hprot  in  4  protection (ignored)
hwdata  in  DATA_WIDTH  write data, valid in the data phase
hreadyi  in  1  bus ready (previous data phase completing)
hrdata  out  DATA_WIDTH  read data
hresp  out  2  OKAY=0, ERROR=1 (RETRY/SPLIT never driven)
hreadyo  out  1  transfer done

Behaviour:
- Reset (async, rst=1): state=IDLE, hreadyo=1, hresp=OKAY, hrdata=0, wait counter=0, latched address-phase regs=0. Memory contents are not reset.
- Accept: an address phase is accepted on a rising edge where hsel & hreadyi & htrans[1]. It latches addr, write, size. IDLE/BUSY, or hsel=0, produce a zero-wait OKAY.
- Error check at accept: error if haddr >= MEM_DEPTH*4, or hsize > 2, or the access is misaligned (half with haddr[0]=1; word with haddr[1:0]!=0).
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE/accept OKAY: go to WAIT and load cnt=WAIT_CYCLES if WAIT_CYCLES>0, else stay IDLE (data phase is 1 cycle).
  - WAIT: hreadyo=0, hresp=OKAY, cnt decrements each cycle. When cnt reaches 1, go to IDLE, so the next cycle is the completing cycle with hreadyo=1.
  - Accept with error: go to ERR1 (hreadyo=0, hresp=ERROR), then ERR2 (hreadyo=1, hresp=ERROR), then IDLE. No memory write occurs for an errored transfer.
  - A new address phase may be accepted in ERR2 or in any hreadyo=1 cycle (hreadyi=hreadyo). Back-to-back transfers run with no bubble.
- Data phase: its length is WAIT_CYCLES+1 cycles; the completing cycle has hreadyo=1.
- Writes: hwdata is sampled only in the completing cycle and committed at that edge. Byte lanes are little-endian, selected by latched size and addr[1:0]: byte→lane addr[1:0]; half→lanes {addr[1],0}+{0,1}; word→all lanes. Unselected bytes are unchanged.
- Reads: hrdata = mem[latched_addr>>2] during the data phase (full word, all lanes). Outside read data phases, hrdata holds its last value. Write-then-read of the same address back-to-back returns the new data, because the write commits before the read's data phase.
- Errors: hrdata is not updated during ERR1/ERR2.
- hburst/hprot have no effect. A SEQ beat is checked independently (range/size/alignment).
- Reset asserted mid-transfer aborts it immediately: outputs go to reset values and no partial write occurs.

Test Plan:
- Reset: assert rst mid-WAIT with WAIT_CYCLES=3 → hreadyo=1, hresp=0, hrdata=0 within the same cycle. After release, the first access is accepted normally.
- Word write/read, WAIT_CYCLES=0: write 0xDEADBEEF @0x10, then read @0x10 back-to-back → hreadyo never low, hrdata=0xDEADBEEF in the read data phase.
- Byte/half lanes: word write 0x00000000 @0x20; byte write 0xAA to @0x21 (hwdata=0x0000AA00); half write 0x1234 to @0x22 (hwdata=0x12340000) → read @0x20 returns 0x1234AA00.
- Wait states, WAIT_CYCLES=3: single read → hreadyo low exactly 3 cycles, then high 1 cycle with valid hrdata. A pipelined second NONSEQ is held on the bus until that completing cycle.
- Error: read @ MEM_DEPTH*4 (0x1000), hsize=3, or word @0x02 → hresp=1 with hreadyo=0 for one cycle, then hresp=1 with hreadyo=1. Errored writes leave memory unchanged (verify by readback).
- IDLE/BUSY and hsel=0 cycles interleaved with transfers → hreadyo=1, hresp=0, no memory change, no state change.
